// File: rtl/vectored_irq_controller.sv
// vectored_irq_controller: memory-mapped interrupt controller with fixed
// priority, nesting, edge/level requests, vector on acknowledge, and NMI.

// Per-line request logic: synchroniser, edge detector and pending latch.
module vic_line (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_async,
    input  logic level,
    input  logic sw_set,
    input  logic ack_clr,
    output logic irr
);
    logic sync1, sync2, prev, pend;

    // Two-flop synchroniser, previous sample, and the latched pending bit.
    // Set terms (software or new edge) win over the acknowledge clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            pend  <= 1'b0;
        end else begin
            sync1 <= irq_async;
            sync2 <= sync1;
            prev  <= sync2;
            pend  <= (pend & ~ack_clr) | sw_set | (~level & sync2 & ~prev);
        end
    end

    // Level lines follow the synchronised input; the latch holds edges and
    // software-set bits in either mode.
    assign irr = pend | (level & sync2);
endmodule

module vectored_irq_controller #(
    parameter int         NUM_IRQS    = 8,
    parameter logic [7:0] VECTOR_BASE = 8'h08
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cs,
    input  logic [1:0]          data_m_addr,
    input  logic [15:0]         data_m_data_in,
    input  logic [1:0]          data_m_bytesel,
    output logic [15:0]         data_m_data_out,
    input  logic                data_m_wr_en,
    input  logic                data_m_access,
    output logic                data_m_ack,
    input  logic [NUM_IRQS-1:0] irq_in,
    input  logic                nmi_in,
    output logic                intr,
    input  logic                inta,
    output logic [7:0]          vector,
    output logic                vector_valid,
    output logic                nmi
);
    localparam int N = NUM_IRQS;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [15:0] wmask;
    } bus_req_t;

    bus_req_t     req;
    logic [N-1:0] imr, elcr, isr, irr;
    logic [N-1:0] wmask_n, wdata_n, sw_set, eoi_clr;
    logic [N-1:0] blk, eligible, onehot, ack_set;
    logic [7:0]   sel_idx;
    logic         found;
    logic         nmi_test, nmi_s1, nmi_s2;
    logic [15:0]  rdata;

    // Decode the bus access into a request; byte enables expand to a bit mask.
    always_comb begin
        req.rd    = cs & data_m_access & ~data_m_wr_en;
        req.wr    = cs & data_m_access & data_m_wr_en;
        req.addr  = data_m_addr;
        req.wmask = {{8{data_m_bytesel[1]}}, {8{data_m_bytesel[0]}}};
    end

    assign wmask_n = req.wmask[N-1:0];
    assign wdata_n = data_m_data_in[N-1:0];
    assign sw_set  = (req.wr && req.addr == 2'd2) ? (wdata_n & wmask_n) : '0;
    assign eoi_clr = (req.wr && req.addr == 2'd3) ? (wdata_n & wmask_n) : '0;

    vic_line u_line [N-1:0] (
        .clk       (clk),
        .reset_n   (reset_n),
        .irq_async (irq_in),
        .level     (elcr),
        .sw_set    (sw_set),
        .ack_clr   (ack_set),
        .irr       (irr)
    );

    // Nesting mask, fixed-priority pick (lowest index wins) and ack one-hot.
    // With nothing eligible the index falls back to the spurious line.
    always_comb begin
        blk     = '0;
        onehot  = '0;
        found   = 1'b0;
        sel_idx = 8'(N - 1);
        blk[0]  = isr[0];
        for (int i = 1; i < N; i++)
            blk[i] = blk[i-1] | isr[i];
        eligible = irr & ~imr & ~blk;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && !found) begin
                found     = 1'b1;
                sel_idx   = 8'(i);
                onehot[i] = 1'b1;
            end
        end
        ack_set = inta ? onehot : '0;
    end

    // Control registers; an acknowledge set of ISR beats a same-cycle EOI.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imr      <= '1;
            elcr     <= '0;
            isr      <= '0;
            nmi_test <= 1'b0;
        end else begin
            if (req.wr && req.addr == 2'd0)
                imr <= (imr & ~wmask_n) | (wdata_n & wmask_n);
            if (req.wr && req.addr == 2'd1)
                elcr <= (elcr & ~wmask_n) | (wdata_n & wmask_n);
            if (req.wr && req.addr == 2'd2 && data_m_bytesel[1])
                nmi_test <= data_m_data_in[15];
            isr <= (isr & ~eoi_clr) | ack_set;
        end
    end

    // Read mux; unimplemented bits read as zero.
    always_comb begin
        rdata = '0;
        case (req.addr)
            2'd0:    rdata = 16'(imr);
            2'd1:    rdata = 16'(elcr);
            2'd2:    rdata = {nmi_test, 15'(irr)};
            default: rdata = 16'(isr);
        endcase
    end

    // Bus response: one-cycle ack, read data only for reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_m_ack      <= 1'b0;
            data_m_data_out <= '0;
        end else begin
            data_m_ack      <= req.rd | req.wr;
            data_m_data_out <= req.rd ? rdata : 16'h0000;
        end
    end

    // CPU side: registered intr, vector capture on acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            intr         <= 1'b0;
            vector       <= '0;
            vector_valid <= 1'b0;
        end else begin
            intr         <= found;
            vector_valid <= inta;
            if (inta)
                vector <= VECTOR_BASE + sel_idx;
        end
    end

    // NMI: synchronised pin ORed with the software test bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nmi_s1 <= 1'b0;
            nmi_s2 <= 1'b0;
            nmi    <= 1'b0;
        end else begin
            nmi_s1 <= nmi_in;
            nmi_s2 <= nmi_s1;
            nmi    <= nmi_s2 | nmi_test;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{data_m_data_in, req.wmask};
endmodule

// File: tb/tb_vectored_irq_controller.sv
// Scoreboard bench for vectored_irq_controller (NUM_IRQS=8, base 8'h08).
module tb_vectored_irq_controller;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cs = 1'b0;
    logic [1:0]   data_m_addr = '0;
    logic [15:0]  data_m_data_in = '0;
    logic [1:0]   data_m_bytesel = '0;
    logic [15:0]  data_m_data_out;
    logic         data_m_wr_en = 1'b0;
    logic         data_m_access = 1'b0;
    logic         data_m_ack;
    logic [N-1:0] irq_in = '0;
    logic         nmi_in = 1'b0;
    logic         intr;
    logic         inta = 1'b0;
    logic [7:0]   vector;
    logic         vector_valid;
    logic         nmi;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_rd[$];
    logic [7:0]  exp_vec[$];

    vectored_irq_controller #(.NUM_IRQS(N), .VECTOR_BASE(8'h08)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .data_m_addr(data_m_addr),
        .data_m_data_in(data_m_data_in), .data_m_bytesel(data_m_bytesel),
        .data_m_data_out(data_m_data_out), .data_m_wr_en(data_m_wr_en),
        .data_m_access(data_m_access), .data_m_ack(data_m_ack),
        .irq_in(irq_in), .nmi_in(nmi_in), .intr(intr), .inta(inta),
        .vector(vector), .vector_valid(vector_valid), .nmi(nmi)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop expected bus data / vectors as the DUT presents them.
    always @(negedge clk) begin
        if (reset_n) begin
            if (data_m_ack) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL bus_ack: unexpected ack, data %h", data_m_data_out);
                end else begin
                    logic [15:0] e;
                    e = exp_rd.pop_front();
                    if (data_m_data_out !== e) begin
                        errors++;
                        $display("FAIL bus_data: got %h want %h", data_m_data_out, e);
                    end
                end
            end
            if (vector_valid) begin
                checks++;
                if (exp_vec.size() == 0) begin
                    errors++;
                    $display("FAIL vector_valid: unexpected pulse, vector %h", vector);
                end else begin
                    logic [7:0] v;
                    v = exp_vec.pop_front();
                    if (vector !== v) begin
                        errors++;
                        $display("FAIL vector: got %h want %h", vector, v);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] be);
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b1;
        data_m_addr = a; data_m_data_in = d; data_m_bytesel = be;
        exp_rd.push_back(16'h0000);
        tick(1);
        cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, input logic [15:0] e);
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0;
        data_m_addr = a; data_m_bytesel = 2'b11;
        exp_rd.push_back(e);
        tick(1);
        cs = 1'b0; data_m_access = 1'b0;
    endtask

    task automatic pulse_irq(input int i);
        irq_in[i] = 1'b1;
        tick(1);
        irq_in[i] = 1'b0;
    endtask

    task automatic do_inta(input logic [7:0] e);
        exp_vec.push_back(e);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
    endtask

    task automatic test_reset;
        tick(2);
        checks++;
        if ({intr, nmi, vector_valid, data_m_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {intr, nmi, vector_valid, data_m_ack});
        end
        checks++;
        if ({vector, data_m_data_out} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 000000", {vector, data_m_data_out});
        end
        reset_n = 1'b1;
        tick(1);
        bus_rd(2'd0, 16'h00FF);
        bus_rd(2'd1, 16'h0000);
        bus_rd(2'd2, 16'h0000);
        bus_rd(2'd3, 16'h0000);
    endtask

    task automatic test_edge;
        bus_wr(2'd0, 16'h0000, 2'b11);
        pulse_irq(3);
        tick(2);
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL edge_intr_early: got %b want 0", intr);
        end
        tick(1);
        checks++;
        if (intr !== 1'b1) begin
            errors++; $display("FAIL edge_intr: got %b want 1", intr);
        end
        do_inta(8'h0B);
        bus_rd(2'd3, 16'h0008);
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL edge_intr_after_ack: got %b want 0", intr);
        end
        bus_rd(2'd2, 16'h0000);
    endtask

    task automatic test_nesting;
        pulse_irq(5);
        tick(4);
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL nest_blocked: got %b want 0", intr);
        end
        bus_rd(2'd2, 16'h0020);
        pulse_irq(1);
        tick(3);
        checks++;
        if (intr !== 1'b1) begin
            errors++; $display("FAIL nest_high: got %b want 1", intr);
        end
        do_inta(8'h09);
        bus_rd(2'd3, 16'h000A);
        bus_wr(2'd3, 16'h0002, 2'b11);
        tick(2);
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL nest_still_blocked: got %b want 0", intr);
        end
        bus_wr(2'd3, 16'h0008, 2'b11);
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL eoi_same_edge: got %b want 0", intr);
        end
        tick(1);
        checks++;
        if (intr !== 1'b1) begin
            errors++; $display("FAIL eoi_intr: got %b want 1", intr);
        end
        do_inta(8'h0D);
        bus_wr(2'd3, 16'h0020, 2'b11);
        bus_rd(2'd2, 16'h0000);
        bus_rd(2'd3, 16'h0000);
    endtask

    task automatic test_level;
        bus_wr(2'd1, 16'h0004, 2'b01);
        irq_in[2] = 1'b1;
        tick(4);
        checks++;
        if (intr !== 1'b1) begin
            errors++; $display("FAIL level_intr: got %b want 1", intr);
        end
        bus_rd(2'd2, 16'h0004);
        do_inta(8'h0A);
        bus_rd(2'd2, 16'h0004);
        bus_rd(2'd3, 16'h0004);
        tick(1);
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL level_in_service: got %b want 0", intr);
        end
        bus_wr(2'd3, 16'h0004, 2'b11);
        tick(1);
        checks++;
        if (intr !== 1'b1) begin
            errors++; $display("FAIL level_reassert: got %b want 1", intr);
        end
        irq_in[2] = 1'b0;
        tick(4);
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL level_drop: got %b want 0", intr);
        end
        bus_rd(2'd2, 16'h0000);
        bus_wr(2'd1, 16'h0000, 2'b11);
    endtask

    task automatic test_spurious;
        bus_wr(2'd0, 16'hFFFF, 2'b11);
        bus_wr(2'd2, 16'h0010, 2'b01);
        bus_rd(2'd0, 16'h00FF);
        bus_rd(2'd2, 16'h0010);
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL masked_intr: got %b want 0", intr);
        end
        do_inta(8'h0F);
        bus_rd(2'd3, 16'h0000);
        bus_rd(2'd2, 16'h0010);
        bus_wr(2'd0, 16'h0000, 2'b11);
        tick(2);
        checks++;
        if (intr !== 1'b1) begin
            errors++; $display("FAIL sw_irr_intr: got %b want 1", intr);
        end
        do_inta(8'h0C);
        bus_rd(2'd2, 16'h0000);
        bus_rd(2'd3, 16'h0010);
        bus_wr(2'd3, 16'h0010, 2'b11);
    endtask

    task automatic test_bytesel;
        bus_wr(2'd0, 16'h00AA, 2'b01);
        bus_wr(2'd0, 16'h0055, 2'b10);
        bus_rd(2'd0, 16'h00AA);
        bus_wr(2'd1, 16'h0011, 2'b10);
        bus_rd(2'd1, 16'h0000);
        bus_wr(2'd0, 16'h0000, 2'b11);
    endtask

    task automatic test_nmi;
        bus_wr(2'd2, 16'h8000, 2'b10);
        checks++;
        if (nmi !== 1'b0) begin
            errors++; $display("FAIL nmi_test_early: got %b want 0", nmi);
        end
        tick(1);
        checks++;
        if (nmi !== 1'b1) begin
            errors++; $display("FAIL nmi_test: got %b want 1", nmi);
        end
        bus_rd(2'd2, 16'h8000);
        bus_wr(2'd2, 16'h0000, 2'b10);
        tick(1);
        checks++;
        if (nmi !== 1'b0) begin
            errors++; $display("FAIL nmi_test_clear: got %b want 0", nmi);
        end
        nmi_in = 1'b1;
        tick(2);
        checks++;
        if (nmi !== 1'b0) begin
            errors++; $display("FAIL nmi_pin_early: got %b want 0", nmi);
        end
        tick(1);
        checks++;
        if (nmi !== 1'b1) begin
            errors++; $display("FAIL nmi_pin: got %b want 1", nmi);
        end
        nmi_in = 1'b0;
        tick(4);
    endtask

    task automatic test_back_to_back;
        irq_in = 8'h41;
        tick(1);
        irq_in = '0;
        tick(3);
        checks++;
        if (intr !== 1'b1) begin
            errors++; $display("FAIL b2b_intr: got %b want 1", intr);
        end
        // Second pulse sees line 0 in service, so line 6 is nested out.
        exp_vec.push_back(8'h08);
        exp_vec.push_back(8'h0F);
        inta = 1'b1;
        tick(2);
        inta = 1'b0;
        bus_rd(2'd3, 16'h0001);
        bus_rd(2'd2, 16'h0040);
        bus_wr(2'd3, 16'h0001, 2'b11);
        tick(1);
        checks++;
        if (intr !== 1'b1) begin
            errors++; $display("FAIL b2b_second_intr: got %b want 1", intr);
        end
        do_inta(8'h0E);
        bus_wr(2'd3, 16'h0040, 2'b11);
        // EOI and acknowledge of the same line on one edge: the set wins.
        pulse_irq(4);
        tick(3);
        exp_vec.push_back(8'h0C);
        exp_rd.push_back(16'h0000);
        inta = 1'b1;
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b1;
        data_m_addr = 2'd3; data_m_data_in = 16'h0010; data_m_bytesel = 2'b11;
        tick(1);
        inta = 1'b0;
        cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
        bus_rd(2'd3, 16'h0010);
        bus_wr(2'd3, 16'h0010, 2'b11);
        bus_rd(2'd3, 16'h0000);
    endtask

    task automatic test_reset_mid;
        pulse_irq(3);
        tick(3);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({intr, nmi, vector_valid, data_m_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL midack_flags: got %b want 0000", {intr, nmi, vector_valid, data_m_ack});
        end
        checks++;
        if ({vector, data_m_data_out} !== 24'h0) begin
            errors++;
            $display("FAIL midack_data: got %h want 000000", {vector, data_m_data_out});
        end
        irq_in[7] = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        bus_rd(2'd0, 16'h00FF);
        bus_rd(2'd3, 16'h0000);
        bus_wr(2'd0, 16'h0000, 2'b11);
        tick(3);
        bus_rd(2'd2, 16'h0080);
        irq_in[7] = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_edge();
        test_nesting();
        test_level();
        test_spurious();
        test_bytesel();
        test_nmi();
        test_back_to_back();
        test_reset_mid();
        tick(2);
        checks++;
        if (exp_rd.size() != 0) begin
            errors++; $display("FAIL bus_drain: got %0d pending want 0", exp_rd.size());
        end
        checks++;
        if (exp_vec.size() != 0) begin
            errors++; $display("FAIL vector_drain: got %0d pending want 0", exp_vec.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vectored_irq_controller.md
# vectored_irq_controller

Parametrised interrupt controller sitting between peripheral IRQ sources and the CPU core's `intr`/`inta` interface, and on the data bus as a memory-mapped slave. It latches up to NUM_IRQS edge- or level-triggered requests, applies masking and fixed priority with nesting, and supplies a vector on acknowledge. It also provides an NMI output fed from a synchronised external pin or a software test bit.

## Interface
- NUM_IRQS, 8, number of request lines, 1..15
- VECTOR_BASE, 8'h08, vector returned for line 0; line i returns VECTOR_BASE+i (8-bit wrap)
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cs  in  1  chip select
- data_m_addr  in  2  register index (word address bits [2:1])
- data_m_data_in  in  16  write data
- data_m_bytesel  in  2  byte enables; bit0 = [7:0], bit1 = [15:8]
- data_m_data_out  out  16  registered read data
- data_m_wr_en  in  1  1 = write, 0 = read
- data_m_access  in  1  bus access strobe
- data_m_ack  out  1  access acknowledge
- irq_in  in  NUM_IRQS  asynchronous request lines
- nmi_in  in  1  asynchronous NMI source
- intr  out  1  interrupt request to the CPU
- inta  in  1  one-cycle acknowledge pulse from the CPU
- vector  out  8  acknowledged vector
- vector_valid  out  1  one-cycle pulse, `vector` valid
- nmi  out  1  non-maskable interrupt

## Operation
- Registers, bits at or above NUM_IRQS read 0 and ignore writes:
  - 0 IMR: 1 = masked; reset all ones.
  - 1 ELCR: 1 = level, 0 = edge; reset 0.
  - 2 IRR: read pending; write-1 sets pending (software test). Bit 15 is `nmi_test` (RW); reset 0.
  - 3 ISR: read in-service; write-1 clears (EOI).
- A write updates only the bytes whose `data_m_bytesel` bit is set.
- `irq_in` and `nmi_in` each pass a 2-flop synchroniser, with sync flops reset to 0.
- Edge mode: a rising edge of the synchronised input (compared with the previous sample, reset 0) sets IRR[i]. IRR[i] is cleared by acknowledge.
- Level mode: IRR[i] = synchronised level OR the software-set bit. Acknowledge does not clear it. A software-set bit clears when the line is acknowledged.
- Priority: lowest index is highest.
  - Eligible = IRR & ~IMR, restricted to indices strictly higher priority than the highest set ISR bit.
  - With ISR = 0, every unmasked pending line is eligible.
- `intr` is registered: it is 1 the cycle after any eligible bit exists.
- On `inta`, the block selects the highest-priority eligible index k. Next cycle:
  - ISR[k] set.
  - Edge-mode IRR[k] cleared.
  - `vector` = VECTOR_BASE+k.
  - `vector_valid` = 1.
- Spurious case (no eligible bit at `inta`): `vector` = VECTOR_BASE+NUM_IRQS-1, `vector_valid` = 1, ISR and IRR unchanged.
- Simultaneous events:
  - A new edge on k in the same cycle as the `inta` clear of k: the set wins and IRR[k] stays 1.
  - An EOI write and an `inta` setting the same ISR bit in the same cycle: the set wins.
  - A software IRR write and a hardware edge: ORed.
  - `inta` asserted on consecutive cycles: each pulse is serviced independently.
- `nmi` is registered: nmi_in_sync | nmi_test.
- Reset (asynchronous, at any time including mid-acknowledge) returns all state to reset values. A line held high through reset in edge mode yields one edge after release.

## Timing
- Reset values: `data_m_ack` 0, `data_m_data_out` 0, `intr` 0, `vector` 0, `vector_valid` 0, `nmi` 0.
- `data_m_ack` = registered (cs & data_m_access): 1 cycle latency.
- `data_m_data_out` is loaded on the same edge. It is 0 unless the access is a read. Writes take effect on that edge.
- `irq_in` rises before edge N:
  - sync1 at N, sync2 at N+1.
  - IRR set at N+2.
  - `intr` at N+3.
- `inta` at edge M: `vector`/`vector_valid` and the ISR/IRR update at M+1. `intr` reflects the updated state at M+2.
- EOI write at edge W: ISR clears at W. A pending lower-priority line raises `intr` at W+1.
- `nmi_in` to `nmi`: 3 edges. `nmi_test` write to `nmi`: 1 edge.

## Test plan
- Reset, then read regs 0-3 with NUM_IRQS=8 -> 16'h00FF, 16'h0000, 16'h0000, 16'h0000. `intr`=0, `nmi`=0.
- Unmask all (IMR=0), pulse irq_in[3] high for 1 cycle -> `intr` 3 edges later. `inta` -> `vector`=8'h0B with `vector_valid` for 1 cycle, ISR=16'h0008, IRR=0.
- ISR bit 3 set, raise irq_in[5] then irq_in[1] -> no `intr` for line 5. `intr` for line 1, `inta` gives 8'h09. EOI ISR=16'h0002 then 16'h0008 -> `intr` rises, next `inta` gives 8'h0D.
- ELCR bit 2 = 1, hold irq_in[2] high -> `inta` gives 8'h0A, IRR[2] stays 1, `intr` stays 0 until EOI, then reasserts. Drop the line -> IRR[2]=0.
- IMR=16'hFFFF, software-set IRR=16'h0010, then `inta` -> spurious `vector`=8'h0F, ISR=0, IRR=16'h0010 unchanged.
- Write reg2 bytesel=2'b10 with 16'h8000 -> `nmi`=1 one edge later. Assert reset_n low mid-acknowledge -> all outputs 0 immediately.
